// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and response signals of the ALU command issuer.
// master = issuer side, slave = scheduler/ALU/consumer side.
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [3:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [WIDTH-1:0] alu_op_a;
  logic [WIDTH-1:0] alu_op_b;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic             rsp_err;
`endif

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  alu_result, alu_zero, rsp_ready,
    output cmd_ready, alu_op_a, alu_op_b, alu_opcode,
    output rsp_valid, rsp_result, rsp_zero, rsp_tag,
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    output rsp_err,
`endif
    output busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output alu_result, alu_zero, rsp_ready,
    input  cmd_ready, alu_op_a, alu_op_b, alu_opcode,
    input  rsp_valid, rsp_result, rsp_zero, rsp_tag,
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    input  rsp_err,
`endif
    input  busy
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: FIFO-buffered commands, one in flight on the ALU.
// Ports: clk, rst_n (async low), bus (alu_cmd_issuer_if.master).
// ALU_ILLEGAL_OP_CHECK_EN adds rsp_err and masks opcodes 8-15.
module alu_cmd_issuer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_cmd_issuer_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE, EXEC, RESP
  } state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] cur_tag;
  state_t           state;
  state_t           state_nx;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.cmd_valid && !full;
  // Pop on issue from IDLE, or back-to-back on response handshake.
  assign pop   = !empty &&
                 ((state == IDLE) ||
                  (state == RESP && bus.rsp_ready));

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{bus.cmd_a, bus.cmd_b,
                       bus.cmd_op, bus.cmd_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!empty) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (bus.rsp_ready)
              state_nx = empty ? IDLE : EXEC;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = !full;
    bus.rsp_valid = (state == RESP);
    bus.busy      = (state != IDLE) || !empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_op_a   <= '0;
      bus.alu_op_b   <= '0;
      bus.alu_opcode <= '0;
      cur_tag        <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_tag    <= '0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      bus.rsp_err    <= 1'b0;
`endif
    end else begin
      if (pop) begin
        bus.alu_op_a   <= head.a;
        bus.alu_op_b   <= head.b;
        bus.alu_opcode <= head.op;
        cur_tag        <= head.tag;
      end
      if (state == EXEC) begin
        bus.rsp_tag <= cur_tag;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        // Opcodes 8-15 are undefined on the ALU.
        if (bus.alu_opcode[3]) begin
          bus.rsp_result <= '0;
          bus.rsp_zero   <= 1'b1;
          bus.rsp_err    <= 1'b1;
        end else begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_zero   <= bus.alu_zero;
          bus.rsp_err    <= 1'b0;
        end
`else
        bus.rsp_result <= bus.alu_result;
        bus.rsp_zero   <= bus.alu_zero;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU.
// Checks latency, ordering, backpressure, wrap and reset.
module tb_alu_cmd_issuer;
  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] SLL  = 4'd5;
  localparam logic [3:0] SLTU = 4'd7;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   acc;

  alu_cmd_issuer_if #(.WIDTH(32), .TAG_W(4)) bus ();

  alu_cmd_issuer #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    unique case (bus.alu_opcode)
      4'd0: bus.alu_result = bus.alu_op_a + bus.alu_op_b;
      4'd1: bus.alu_result = bus.alu_op_a - bus.alu_op_b;
      4'd2: bus.alu_result = bus.alu_op_a & bus.alu_op_b;
      4'd3: bus.alu_result = bus.alu_op_a | bus.alu_op_b;
      4'd4: bus.alu_result = bus.alu_op_a ^ bus.alu_op_b;
      4'd5: bus.alu_result = bus.alu_op_a << bus.alu_op_b[4:0];
      4'd6: bus.alu_result = bus.alu_op_a >> bus.alu_op_b[4:0];
      4'd7: bus.alu_result = {31'd0, bus.alu_op_a < bus.alu_op_b};
      default: bus.alu_result = bus.alu_op_a;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [3:0] tag);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_tag   = tag;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.cmd_ready; i++) tick();
    chk("push_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) tick();
    chk("rsp_wait", 64'(bus.rsp_valid), 64'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) tick();
    chk("rst_op_a", 64'(bus.alu_op_a), 64'd0);
    chk("rst_opcode", 64'(bus.alu_opcode), 64'd0);
    chk("rst_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_tag", 64'(bus.rsp_tag), 64'd0);
    chk("rst_zero", 64'(bus.rsp_zero), 64'd0);
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 64'(bus.cmd_ready), 64'd1);

    // single ADD: response two cycles after push edge
    bus.rsp_ready = 1'b1;
    push(32'd5, 32'd3, ADD, 4'd1);
    chk("lat_t0_valid", 64'(bus.rsp_valid), 64'd0);
    chk("lat_t0_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("lat_t1_valid", 64'(bus.rsp_valid), 64'd0);
    chk("lat_t1_op_a", 64'(bus.alu_op_a), 64'd5);
    tick();
    chk("add_valid", 64'(bus.rsp_valid), 64'd1);
    chk("add_result", 64'(bus.rsp_result), 64'd8);
    chk("add_zero", 64'(bus.rsp_zero), 64'd0);
    chk("add_tag", 64'(bus.rsp_tag), 64'd1);
    tick();
    chk("add_done_valid", 64'(bus.rsp_valid), 64'd0);
    chk("add_done_busy", 64'(bus.busy), 64'd0);

    push(32'd7, 32'd7, SUB, 4'd2);
    wait_rsp();
    chk("sub_result", 64'(bus.rsp_result), 64'd0);
    chk("sub_zero", 64'(bus.rsp_zero), 64'd1);
    chk("sub_tag", 64'(bus.rsp_tag), 64'd2);
    tick();
    push(32'd2, 32'd9, SLTU, 4'd3);
    wait_rsp();
    chk("sltu_result", 64'(bus.rsp_result), 64'd1);
    chk("sltu_zero", 64'(bus.rsp_zero), 64'd0);
    chk("sltu_tag", 64'(bus.rsp_tag), 64'd3);
    tick();

    // backpressure: 6 offers, 5 fit (4 queued + 1 held)
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 6; t++) begin
      bus.cmd_a     = 32'(t);
      bus.cmd_b     = 32'd16;
      bus.cmd_op    = ADD;
      bus.cmd_tag   = 4'(t);
      bus.cmd_valid = 1'b1;
      if (bus.cmd_ready) acc++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_ready_low", 64'(bus.cmd_ready), 64'd0);
    chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_tag0", 64'(bus.rsp_tag), 64'd0);
    repeat (2) tick();
    chk("bp_tag0_hold", 64'(bus.rsp_tag), 64'd0);
    chk("bp_res0_hold", 64'(bus.rsp_result), 64'd16);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp();
      chk("bp_order_tag", 64'(bus.rsp_tag), 64'(i));
      chk("bp_order_res", 64'(bus.rsp_result), 64'(i + 16));
      tick();
      if (i == 0)
        chk("bp_ready_back", 64'(bus.cmd_ready), 64'd1);
    end
    chk("bp_idle_busy", 64'(bus.busy), 64'd0);

    // streaming 12 shifts across pointer wrap
    fork
      begin
        for (int k = 0; k < 12; k++)
          push(32'd1, 32'(k), SLL, 4'(k));
      end
      begin
        for (int k = 0; k < 12; k++) begin
          wait_rsp();
          chk("wrap_result", 64'(bus.rsp_result), 64'(32'd1 << k));
          chk("wrap_tag", 64'(bus.rsp_tag), 64'(k));
          tick();
        end
      end
    join
    repeat (3) tick();
    chk("wrap_no_extra", 64'(bus.rsp_valid), 64'd0);
    chk("wrap_busy", 64'(bus.busy), 64'd0);

    // reset while holding a response with 3 queued
    bus.rsp_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      push(32'(k), 32'd0, ADD, 4'(k));
    chk("mid_valid", 64'(bus.rsp_valid), 64'd1);
    chk("mid_full", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mr_ready", 64'(bus.cmd_ready), 64'd1);
    chk("mr_busy", 64'(bus.busy), 64'd0);
    chk("mr_tag", 64'(bus.rsp_tag), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (4) tick();
    chk("mr_no_stale", 64'(bus.rsp_valid), 64'd0);
    chk("mr_idle", 64'(bus.busy), 64'd0);
    chk("mr_op_a", 64'(bus.alu_op_a), 64'd0);

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    push(32'hFFFF_FFFF, 32'd0, 4'b1010, 4'd6);
    wait_rsp();
    chk("ill_err", 64'(bus.rsp_err), 64'd1);
    chk("ill_result", 64'(bus.rsp_result), 64'd0);
    chk("ill_zero", 64'(bus.rsp_zero), 64'd1);
    tick();
    push(32'd1, 32'd1, ADD, 4'd7);
    wait_rsp();
    chk("legal_err", 64'(bus.rsp_err), 64'd0);
    chk("legal_result", 64'(bus.rsp_result), 64'd2);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
